// File: rtl/mmu_arb_pkg.sv
// Shared types for the two-master MMU port arbiter.
// Master ids, read-return tags and latency bound.
package mmu_arb_pkg;

    typedef logic master_id_t;

    localparam master_id_t MASTER_CORE = 1'b0;
    localparam master_id_t MASTER_DMA  = 1'b1;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

    localparam int MAX_RD_LATENCY = 4;

endpackage

// File: rtl/mmu_arb_rd_tracker.sv
// Read-return tag pipeline: follows each granted read through the MMU
// latency and pulses the owning master's rd_valid when data arrives.
module mmu_arb_rd_tracker
    import mmu_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rstb,
    input  rd_tag_t push_i,
    output logic    m0_rd_valid_o,
    output logic    m1_rd_valid_o
);

    localparam int DEPTH = (RD_LATENCY < 1) ? 1 :
                           (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                           RD_LATENCY;

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign m0_rd_valid_o = pipe_q[DEPTH-1].valid &&
                           (pipe_q[DEPTH-1].id == MASTER_CORE);
    assign m1_rd_valid_o = pipe_q[DEPTH-1].valid &&
                           (pipe_q[DEPTH-1].id == MASTER_DMA);

endmodule

// File: rtl/mmu_bus_arbiter.sv
// Two-master arbiter for the single MMU port: same-cycle grant,
// round-robin on contention, bounded lock for atomic sequences.
module mmu_bus_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic        m0_wr_ena,
    input  logic [31:0] m0_wr_data,
    output logic        m0_gnt,
    output logic        m0_rd_valid,
    output logic [31:0] m0_rd_data,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic        m1_wr_ena,
    input  logic [31:0] m1_wr_data,
    output logic        m1_gnt,
    output logic        m1_rd_valid,
    output logic [31:0] m1_rd_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr_ena,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    output logic        owner
);

    localparam logic [8:0] LOCK_LIM = 9'(LOCK_MAX);

    master_id_t rr_last_q, rr_last_d;
    master_id_t lock_id_q, lock_id_d;
    logic       lock_q, lock_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [8:0] cnt_inc;
    logic       gnt_any;
    master_id_t gnt_id;
    logic       sel_lock;
    logic       sel_wr;
    logic       hold_req;
    logic       hold_lock;
    rd_tag_t    push_tag;

    // Grants are forced low while reset is asserted, not just at the next edge.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rstb) begin
            if (lock_q) begin
                m0_gnt = m0_req && (lock_id_q == MASTER_CORE);
                m1_gnt = m1_req && (lock_id_q == MASTER_DMA);
            end else if (m0_req && m1_req) begin
                m0_gnt = (rr_last_q != MASTER_CORE);
                m1_gnt = (rr_last_q == MASTER_CORE);
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign gnt_any = m0_gnt || m1_gnt;
    assign gnt_id  = m1_gnt ? MASTER_DMA : MASTER_CORE;
    assign owner   = m1_gnt;

    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        sel_lock    = 1'b0;
        sel_wr      = 1'b0;
        if (m0_gnt) begin
            mem_addr    = m0_addr;
            mem_wr_data = m0_wr_data;
            mem_wr_ena  = m0_wr_ena;
            sel_lock    = m0_lock;
            sel_wr      = m0_wr_ena;
        end else if (m1_gnt) begin
            mem_addr    = m1_addr;
            mem_wr_data = m1_wr_data;
            mem_wr_ena  = m1_wr_ena;
            sel_lock    = m1_lock;
            sel_wr      = m1_wr_ena;
        end
    end

    assign hold_req  = (lock_id_q == MASTER_DMA) ? m1_req  : m0_req;
    assign hold_lock = (lock_id_q == MASTER_DMA) ? m1_lock : m0_lock;

    // While locked, any grant goes to the holder, so the count just continues.
    always_comb begin
        rr_last_d  = rr_last_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = (lock_q ? {1'b0, lock_cnt_q} : 9'd0) + 9'd1;
        if (gnt_any) begin
            rr_last_d = gnt_id;
        end
        if (gnt_any && sel_lock) begin
            if (cnt_inc == LOCK_LIM) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end else begin
                lock_d     = 1'b1;
                lock_id_d  = gnt_id;
                lock_cnt_d = cnt_inc[7:0];
            end
        end else if (lock_q && (gnt_any || (!hold_req && !hold_lock))) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rr_last_q  <= MASTER_DMA;
            lock_q     <= 1'b0;
            lock_id_q  <= MASTER_CORE;
            lock_cnt_q <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign push_tag.valid = gnt_any && !sel_wr;
    assign push_tag.id    = gnt_id;

    mmu_arb_rd_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk           (clk),
        .rstb          (rstb),
        .push_i        (push_tag),
        .m0_rd_valid_o (m0_rd_valid),
        .m1_rd_valid_o (m1_rd_valid)
    );

    assign m0_rd_data = mem_rd_data;
    assign m1_rd_data = mem_rd_data;

endmodule
